// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: CPU memory access to byte-enabled req/ack memory port
// Word-aligned request with lane replication on stores and sign/zero extraction on loads.
module lsu #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rest,
   input  logic        dm_rd,
   input  logic        dm_wr,
   input  logic [2:0]  dm_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err_align,
   output logic        err_timeout,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [1:0]        lane_q, lane_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_align_q, err_align_d;
   logic              err_timeout_q, err_timeout_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   function automatic logic is_half(input logic [2:0] op);
      return (op == 3'b001) || (op == 3'b010);
   endfunction

   function automatic logic is_byte(input logic [2:0] op);
      return (op == 3'b011) || (op == 3'b100);
   endfunction

   function automatic logic is_signed(input logic [2:0] op);
      return (op == 3'b001) || (op == 3'b011);
   endfunction

   logic        in_aligned;
   logic [3:0]  in_be;
   logic [31:0] in_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   always_comb begin
      in_aligned = 1'b1;
      in_be      = 4'b1111;
      in_wdata   = wdata;
      if (is_half(dm_op)) begin
         in_aligned = ~addr[0];
         in_be      = addr[1] ? 4'b1100 : 4'b0011;
         in_wdata   = {2{wdata[15:0]}};
      end else if (is_byte(dm_op)) begin
         in_be      = 4'b0001 << addr[1:0];
         in_wdata   = {4{wdata[7:0]}};
      end else begin
         in_aligned = (addr[1:0] == 2'b00);
      end
   end

   // Lane selection uses the offset captured at acceptance, not the live address.
   always_comb begin
      ld_byte = mem_rdata[8*lane_q +: 8];
      ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_ext  = mem_rdata;
      if (is_half(op_q)) begin
         ld_ext = {{16{is_signed(op_q) & ld_half[15]}}, ld_half};
      end else if (is_byte(op_q)) begin
         ld_ext = {{24{is_signed(op_q) & ld_byte[7]}}, ld_byte};
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      lane_d        = lane_q;
      cnt_d         = cnt_q;
      rdata_d       = rdata_q;
      err_align_d   = err_align_q;
      err_timeout_d = err_timeout_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_be_d      = mem_be_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (dm_rd || dm_wr) begin
               op_d        = dm_op;
               lane_d      = addr[1:0];
               cnt_d       = '0;
               mem_we_d    = dm_wr;
               mem_be_d    = in_be;
               mem_addr_d  = {addr[31:2], 2'b00};
               mem_wdata_d = in_wdata;
               if (in_aligned) begin
                  state_d   = REQ;
                  mem_req_d = 1'b1;
               end else begin
                  state_d     = DONE;
                  err_align_d = 1'b1;
                  rdata_d     = '0;
               end
            end
         end
         REQ: begin
            if (mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               rdata_d   = mem_we_q ? 32'd0 : ld_ext;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               state_d       = DONE;
               mem_req_d     = 1'b0;
               err_timeout_d = 1'b1;
               rdata_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d       = IDLE;
            err_align_d   = 1'b0;
            err_timeout_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state_q       <= IDLE;
         op_q          <= '0;
         lane_q        <= '0;
         cnt_q         <= '0;
         rdata_q       <= '0;
         err_align_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_be_q      <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         lane_q        <= lane_d;
         cnt_q         <= cnt_d;
         rdata_q       <= rdata_d;
         err_align_q   <= err_align_d;
         err_timeout_q <= err_timeout_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_be_q      <= mem_be_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign rdata       = rdata_q;
   assign ready       = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign err_align   = err_align_q;
   assign err_timeout = err_timeout_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_be      = mem_be_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule
